// File: rtl/sar_seq_pkg.sv
// Shared definitions for the SAR conversion sequencer.
// Holds the FSM state encoding, the default resolution and a helper that
// sizes the saturating wait-timer from its terminal count.
package sar_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONV,
    ST_LATCH,
    ST_RELEASE,
    ST_DONE
  } state_t;

  localparam int NBIT_DEFAULT = 10;

  // Bits needed to hold 0..max_count inclusive (timer saturates at max_count).
  function automatic int timer_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sar_seq_sync.sv
// Reset-to-0 multi-flop synchronizer for one asynchronous comparator output.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, clears every stage
//   d    - asynchronous input
//   q    - synchronized output, STAGES clock edges behind d
module sar_seq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sar_seq.sv
// SAR conversion sequencer for the capacitive-DAC switch controller.
// Drives sampling (CKSB), the comparator clock (CKC) and one-hot bit-latch
// strobes (CF), collects comparator decisions MSB first and publishes the
// finished code on DOUT with a one-cycle DVALID pulse.
// Ports:
//   CLK, RST     - clock, asynchronous active-high reset
//   START        - conversion request, honoured only in IDLE
//   CMP_P, CMP_N - asynchronous comparator outputs (P high = DAC below input)
//   CKSB         - low = sample/track, high = convert/hold
//   CKC          - comparator clock, high = evaluate
//   CF           - one-hot bit-latch strobes
//   DOUT         - last completed code
//   DVALID       - one-cycle pulse when DOUT updates
//   BUSY         - high from SAMPLE through DONE
//   TIMEOUT_ERR  - sticky comparator timeout flag for the current/last conversion
module sar_seq
  import sar_seq_pkg::*;
#(
  parameter int NBIT        = NBIT_DEFAULT,
  parameter int SAMPLE_CYC  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CMP_TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            CMP_P,
  input  logic            CMP_N,
  output logic            CKSB,
  output logic            CKC,
  output logic [NBIT-1:0] CF,
  output logic [NBIT-1:0] DOUT,
  output logic            DVALID,
  output logic            BUSY,
  output logic            TIMEOUT_ERR
);

  localparam int TW = timer_width(CMP_TIMEOUT);
  localparam int SW = $clog2(SAMPLE_CYC + 1);
  localparam int IW = (NBIT > 1) ? $clog2(NBIT) : 1;

  logic cp, cn;

  sar_seq_sync #(.STAGES(SYNC_STAGES)) u_sync_p (
    .clk(CLK), .rst(RST), .d(CMP_P), .q(cp)
  );

  sar_seq_sync #(.STAGES(SYNC_STAGES)) u_sync_n (
    .clk(CLK), .rst(RST), .d(CMP_N), .q(cn)
  );

  state_t          state, state_n;
  logic [IW-1:0]   bit_idx, bit_n;
  logic [SW-1:0]   sample_cnt, sample_n;
  logic [TW-1:0]   wait_cnt, wait_n;
  logic [NBIT-1:0] shadow, shadow_n;
  logic [NBIT-1:0] dout_n, cf_n;
  logic            terr_n, cksb_n, ckc_n, busy_n, dvalid_n;

  // Exactly one of cp/cn high is a decision; both high is an invalid
  // comparator state and is treated the same as no answer yet.
  logic ready, quiet, wait_last, sample_last;
  assign ready       = cp ^ cn;
  assign quiet       = ~cp & ~cn;
  assign wait_last   = (wait_cnt == TW'(CMP_TIMEOUT - 1));
  assign sample_last = (sample_cnt == SW'(SAMPLE_CYC - 1));

  // NOTE: every outputs is decoded from the *next* state and registered, so
  // CF/CKC change only on clock edges and can never glitch; every variable
  // gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    state_n  = state;
    bit_n    = bit_idx;
    sample_n = sample_cnt;
    wait_n   = (wait_cnt == TW'(CMP_TIMEOUT)) ? wait_cnt : wait_cnt + TW'(1);
    shadow_n = shadow;
    dout_n   = DOUT;
    terr_n   = TIMEOUT_ERR;

    unique case (state)
      ST_IDLE: begin
        if (START) begin
          state_n  = ST_SAMPLE;
          sample_n = '0;
          bit_n    = IW'(NBIT - 1);
          shadow_n = '0;
          terr_n   = 1'b0;
        end
      end
      ST_SAMPLE: begin
        sample_n = sample_cnt + SW'(1);
        if (sample_last) begin
          state_n = ST_CONV;
          wait_n  = '0;
        end
      end
      ST_CONV: begin
        if (ready) begin
          shadow_n[bit_idx] = cp;
          state_n           = ST_LATCH;
        end else if (wait_last) begin
          shadow_n[bit_idx] = 1'b0;
          terr_n            = 1'b1;
          state_n           = ST_LATCH;
        end
      end
      ST_LATCH: begin
        state_n = ST_RELEASE;
        wait_n  = '0;
      end
      ST_RELEASE: begin
        if (quiet || wait_last) begin
          if (!quiet) terr_n = 1'b1;
          if (bit_idx != '0) begin
            bit_n   = bit_idx - IW'(1);
            state_n = ST_CONV;
            wait_n  = '0;
          end else begin
            state_n = ST_DONE;
            dout_n  = shadow;
          end
        end
      end
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase

    cksb_n   = !(state_n == ST_IDLE || state_n == ST_SAMPLE);
    ckc_n    = (state_n == ST_CONV) || (state_n == ST_LATCH);
    cf_n     = (state_n == ST_LATCH) ? (NBIT'(1) << bit_n) : '0;
    busy_n   = (state_n != ST_IDLE);
    dvalid_n = (state_n == ST_DONE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      bit_idx     <= '0;
      sample_cnt  <= '0;
      wait_cnt    <= '0;
      shadow      <= '0;
      CKSB        <= 1'b0;
      CKC         <= 1'b0;
      CF          <= '0;
      DOUT        <= '0;
      DVALID      <= 1'b0;
      BUSY        <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state       <= state_n;
      bit_idx     <= bit_n;
      sample_cnt  <= sample_n;
      wait_cnt    <= wait_n;
      shadow      <= shadow_n;
      CKSB        <= cksb_n;
      CKC         <= ckc_n;
      CF          <= cf_n;
      DOUT        <= dout_n;
      DVALID      <= dvalid_n;
      BUSY        <= busy_n;
      TIMEOUT_ERR <= terr_n;
    end
  end

endmodule

// File: tb/tb_sar_seq.sv
// Self-checking bench for sar_seq: an analog-level comparator model (binary
// search DAC compare, or stuck outputs) drives the DUT; conversion results,
// timing and strobe order are checked against values derived from the
// conversion rules.
module tb_sar_seq;

  localparam int NBIT = 10;
  localparam int SCYC = 4;
  localparam int SYNC = 2;
  localparam int TMO  = 16;

  localparam int M_IDEAL = 0;
  localparam int M_ZERO  = 1;
  localparam int M_ONE   = 2;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic            START = 1'b0;
  logic            CMP_P, CMP_N;
  logic            CKSB, CKC, DVALID, BUSY, TIMEOUT_ERR;
  logic [NBIT-1:0] CF, DOUT;

  sar_seq #(
    .NBIT(NBIT), .SAMPLE_CYC(SCYC), .SYNC_STAGES(SYNC), .CMP_TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .CMP_P(CMP_P), .CMP_N(CMP_N),
    .CKSB(CKSB), .CKC(CKC), .CF(CF), .DOUT(DOUT), .DVALID(DVALID),
    .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- comparator / DAC model ----------------
  int              mode = M_IDEAL;
  logic [NBIT-1:0] vin = '0;
  logic [NBIT-1:0] dec = '0;
  int              idx = NBIT - 1;
  logic            pend = 1'b0;
  logic [NBIT-1:0] trial;

  always_comb begin
    trial = dec;
    if (idx >= 0) trial[idx] = 1'b1;
    case (mode)
      M_ZERO:  begin CMP_P = 1'b0; CMP_N = 1'b0; end
      M_ONE:   begin CMP_P = 1'b1; CMP_N = 1'b1; end
      default: begin
        CMP_P = CKC && (trial <= vin);
        CMP_N = CKC && !(trial <= vin);
      end
    endcase
  end

  // Switch controller: latch the decision on the CF strobe, move to the next
  // bit once the comparator has been released.
  always @(negedge CLK) begin
    if (!CKSB) begin
      idx  <= NBIT - 1;
      dec  <= '0;
      pend <= 1'b0;
    end else if (CF != '0 && !pend) begin
      dec[idx] <= CMP_P;
      pend     <= 1'b1;
    end else if (!CKC && pend) begin
      idx  <= idx - 1;
      pend <= 1'b0;
    end
  end

  // ---------------- monitor ----------------
  function automatic int bit_of(input logic [NBIT-1:0] v);
    for (int i = 0; i < NBIT; i++) if (v[i]) return i;
    return -1;
  endfunction

  logic busy_q = 1'b0, ckc_q = 1'b0;
  int   acc_cyc = 0, ckc_rise = -1, cf_cnt = 0, cf_bad = 0;
  int   dv_cnt = 0, dv_cyc = 0;
  int   cf_cyc [NBIT];
  int   cf_bit [NBIT];

  always @(negedge CLK) begin
    busy_q <= BUSY;
    ckc_q  <= CKC;
    if (BUSY && !busy_q) begin
      acc_cyc  <= cyc;
      ckc_rise <= -1;
      cf_cnt   <= 0;
    end else begin
      if (CKC && !ckc_q && ckc_rise < 0) ckc_rise <= cyc;
      if (CF != '0) begin
        if (!$onehot(CF)) cf_bad <= cf_bad + 1;
        if (cf_cnt < NBIT) begin
          cf_cyc[cf_cnt] <= cyc;
          cf_bit[cf_cnt] <= bit_of(CF);
        end
        cf_cnt <= cf_cnt + 1;
      end
    end
    if (DVALID) begin
      dv_cnt <= dv_cnt + 1;
      dv_cyc <= cyc;
    end
  end

  // ---------------- helpers ----------------
  function automatic int conv_len(input int m);
    return (m == M_IDEAL) ? SYNC + 1 : TMO;
  endfunction

  function automatic int per_bit(input int m);
    int rel;
    rel = (m == M_IDEAL) ? SYNC + 1 : (m == M_ZERO) ? 1 : TMO;
    return conv_len(m) + 1 + rel;
  endfunction

  task automatic start_pulse();
    @(negedge CLK) START = 1'b1;
    @(negedge CLK) START = 1'b0;
  endtask

  task automatic wait_dv(input string tag, input int budget);
    int n0;
    bit seen;
    n0   = dv_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK);
      if (dv_cnt != n0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({tag, "_dvalid_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_conv(input string tag, input logic [NBIT-1:0] code, input int m);
    int n0, exp_lat;
    mode = m;
    vin  = code;
    n0   = dv_cnt;
    start_pulse();
    wait_dv(tag, 600);
    exp_lat = SCYC + NBIT * per_bit(m);
    check({tag, "_dout"}, 32'(DOUT), (m == M_IDEAL) ? 32'(code) : 32'd0);
    check({tag, "_terr"}, 32'(TIMEOUT_ERR), (m == M_IDEAL) ? 32'd0 : 32'd1);
    check({tag, "_latency"}, 32'(dv_cyc - acc_cyc), 32'(exp_lat));
    check({tag, "_sample_len"}, 32'(ckc_rise - acc_cyc), 32'(SCYC));
    check({tag, "_cf_count"}, 32'(cf_cnt), 32'(NBIT));
    check({tag, "_cf_onehot"}, 32'(cf_bad), 32'd0);
    for (int j = 0; j < NBIT; j++) begin
      check({tag, "_cf_bit"}, 32'(cf_bit[j]), 32'(NBIT - 1 - j));
      check({tag, "_cf_time"}, 32'(cf_cyc[j] - acc_cyc),
            32'(SCYC + conv_len(m) + j * per_bit(m)));
    end
    @(negedge CLK);
    check({tag, "_dvalid_pulse"}, 32'(DVALID), 32'd0);
    check({tag, "_idle_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_dv_count"}, 32'(dv_cnt - n0), 32'd1);
    repeat (3) @(negedge CLK);
    check({tag, "_dout_hold"}, 32'(DOUT), (m == M_IDEAL) ? 32'(code) : 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0, t1, found;
    logic [NBIT-1:0] rc;

    #2 RST = 1'b1;
    #1;
    check("reset_outputs", 32'({CKSB, CKC, CF, DOUT, DVALID, BUSY, TIMEOUT_ERR}), 32'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    repeat (2) @(negedge CLK);

    run_conv("code_2aa", 10'h2AA, M_IDEAL);
    run_conv("code_000", 10'h000, M_IDEAL);
    run_conv("code_3ff", 10'h3FF, M_IDEAL);
    for (int k = 0; k < 4; k++) begin
      rc = NBIT'($urandom_range(0, (1 << NBIT) - 1));
      run_conv("code_rand", rc, M_IDEAL);
    end

    // Silent comparator: every bit times out; next START clears the flag.
    run_conv("stuck00", 10'h155, M_ZERO);
    mode = M_IDEAL;
    vin  = 10'h0F0;
    start_pulse();
    repeat (2) @(negedge CLK);
    check("terr_cleared_on_start", 32'(TIMEOUT_ERR), 32'd0);
    wait_dv("after_stuck", 600);
    check("after_stuck_dout", 32'(DOUT), 32'h0F0);
    repeat (3) @(negedge CLK);

    run_conv("stuck11", 10'h3C3, M_ONE);
    mode = M_IDEAL;
    repeat (3) @(negedge CLK);

    // Reset during CONV of bit 5.
    vin = NBIT'($urandom_range(0, (1 << NBIT) - 1));
    n0  = dv_cnt;
    start_pulse();
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK);
      #2;
      if (cf_cnt == 4 && CKC && CF == '0) begin
        found = 1;
        break;
      end
    end
    check("reach_conv_bit5", 32'(found), 32'd1);
    RST = 1'b1;
    #1;
    check("midconv_reset_outputs",
          32'({CKSB, CKC, CF, DOUT, DVALID, BUSY, TIMEOUT_ERR}), 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (100) @(negedge CLK);
    check("midconv_no_dvalid", 32'(dv_cnt - n0), 32'd0);
    run_conv("post_reset_155", 10'h155, M_IDEAL);

    // START pulse while busy is ignored.
    vin = 10'h1A5;
    n0  = dv_cnt;
    start_pulse();
    repeat (20) @(negedge CLK);
    START = 1'b1;
    @(negedge CLK) START = 1'b0;
    wait_dv("busy_start", 600);
    repeat (120) @(negedge CLK);
    check("busy_start_one_dvalid", 32'(dv_cnt - n0), 32'd1);
    check("busy_start_dout", 32'(DOUT), 32'h1A5);

    // START held high: back-to-back conversions.
    vin = NBIT'($urandom_range(0, (1 << NBIT) - 1));
    @(negedge CLK) START = 1'b1;
    wait_dv("held_first", 600);
    t1 = dv_cyc;
    check("held_first_dout", 32'(DOUT), 32'(vin));
    wait_dv("held_second", 600);
    #1 START = 1'b0;
    check("held_spacing", 32'(dv_cyc - t1), 32'(SCYC + NBIT * per_bit(M_IDEAL) + 2));
    check("held_second_dout", 32'(DOUT), 32'(vin));
    repeat (5) @(negedge CLK);
    check("held_release_idle", 32'(BUSY), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_seq.md
Name: sar_seq

Overview:
Synchronous SAR conversion sequencer that drives the capacitive-DAC switch controller in the 10-bit SAR ADC.
- Generates the sampling signal CKSB, the comparator clock CKC and the one-hot bit-latch strobes CF[9:0].
- Watches the comparator outputs CMP_P/CMP_N and assembles the output code DOUT, signalled by a DVALID pulse.
- Sits between the digital front end (START/DOUT) and the analog core (comparator, switch controller).

Parameters:
NBIT, 10, conversion resolution; width of CF and DOUT.
SAMPLE_CYC, 4, CLK cycles CKSB is held low for sampling (minimum 1).
SYNC_STAGES, 2, flop stages in the CMP_P/CMP_N synchronizers (minimum 2).
CMP_TIMEOUT, 16, maximum cycles waited in CONV or RELEASE before forcing progress.

Ports:
CLK  input  1  system clock.
RST  input  1  asynchronous, active-high reset.
START  input  1  conversion request; sampled only in IDLE.
CMP_P  input  1  comparator positive output, asynchronous; high = DAC below input.
CMP_N  input  1  comparator negative output, asynchronous.
CKSB  output  1  low = sample/track, which also clears the switch controller; high = convert/hold.
CKC  output  1  comparator clock; high = evaluate, low = reset comparator.
CF  output  NBIT  one-hot bit-latch strobes; CF[i] rises while the bit-i decision is valid.
DOUT  output  NBIT  last completed code, MSB = bit NBIT-1.
DVALID  output  1  one-cycle pulse; DOUT updated in the same cycle.
BUSY  output  1  high from SAMPLE entry through DONE.
TIMEOUT_ERR  output  1  sticky; a comparator timeout occurred during the current or last conversion.

Behaviour:
- All outputs are registered; the values listed below are held while the FSM is in the given state. No combinational glitches on CF or CKC.
- RST asserted: immediately CKSB=0, CKC=0, CF=0, DOUT=0, DVALID=0, BUSY=0, TIMEOUT_ERR=0. State = IDLE, synchronizers cleared.
- RST mid-conversion aborts with the same values; the partial code is discarded.
- Synchronized flags: cp, cn = CMP_P, CMP_N after SYNC_STAGES flops.
  - ready = cp XOR cn.
  - cp=cn=1 is invalid and treated as not ready.
- IDLE: CKSB=0, CKC=0, CF=0, BUSY=0.
  - START=1 → SAMPLE. Sample-timer cleared, bit index = NBIT-1, TIMEOUT_ERR cleared.
- SAMPLE: CKSB=0, BUSY=1. Stays SAMPLE_CYC cycles → CONV.
- CONV: CKSB=1, CKC=1, wait-timer counting.
  - ready → LATCH, shadow[bit] = cp.
  - Wait-timer reaches CMP_TIMEOUT → LATCH, shadow[bit] = 0, TIMEOUT_ERR = 1.
- LATCH: CKC=1, CF[bit]=1 (only that bit), exactly one cycle → RELEASE.
- RELEASE: CKC=0, CF=0, wait-timer counting.
  - Leaves when cp=0 and cn=0, or when the wait-timer reaches CMP_TIMEOUT (then TIMEOUT_ERR = 1).
  - If bit > 0: decrement bit and go to CONV. Otherwise go to DONE.
- DONE: CKSB=1, DOUT = shadow, DVALID=1 for one cycle → IDLE.
- Ideal comparator (responds within the cycle CKC changes):
  - CONV lasts SYNC_STAGES+1 cycles, LATCH 1, RELEASE SYNC_STAGES+1.
  - Per bit: 2·SYNC_STAGES+3 cycles, i.e. 7 at default.
  - DVALID asserts SAMPLE_CYC + NBIT·(2·SYNC_STAGES+3) edges after the edge that accepted START; 74 at defaults.
- START outside IDLE is ignored; there is no queuing.
- START held high continuously gives back-to-back conversions, each accepted one cycle after DONE.
- The wait-timer is cleared on every CONV or RELEASE entry and saturates at CMP_TIMEOUT.
- DOUT holds its value between DVALID pulses. TIMEOUT_ERR holds until the next accepted START or RST.

Decomposition:
- Shared include sar_defs.vh holds:
  - state encodings: IDLE, SAMPLE, CONV, LATCH, RELEASE, DONE;
  - default NBIT;
  - timer width derived from CMP_TIMEOUT via $clog2.
- One sub-module, sar_sync: SYNC_STAGES-deep reset-to-0 synchronizer, instantiated for CMP_P and CMP_N.
- Remaining logic, in sar_seq: FSM, bit index, timers, shadow register.

Test Plan:
- Ideal comparator model with input code 10'h2AA, START pulse.
  → CF strobes CF[9]..CF[0], one each, 7 cycles apart. DVALID 74 cycles after accept, DOUT = 10'h2AA, TIMEOUT_ERR = 0.
- Codes 10'h000 and 10'h3FF.
  → DOUT matches. CKSB low exactly 4 cycles before the first CKC rise.
- Comparator stuck cp=cn=0 (no response).
  → every bit times out. DOUT = 10'h000, TIMEOUT_ERR = 1, each CONV lasts 16 cycles.
  → next START clears TIMEOUT_ERR.
- Comparator stuck cp=cn=1.
  → treated as not ready: CONV and RELEASE both time out. DOUT = 10'h000, TIMEOUT_ERR = 1.
- RST asserted during CONV of bit 5.
  → outputs immediately at reset values, no DVALID. A subsequent START converts 10'h155 correctly.
- START pulsed during BUSY, and START held high.
  → the pulse is ignored (exactly one DVALID). Held START gives consecutive DVALIDs 76 cycles apart (74 + DONE + IDLE accept).
